// File: rtl/state_frame_decoder_if.sv
// Purpose: bundles the serial input line and the decoded parallel outputs of
//          state_frame_decoder into one interface.
// Signals:
//   serIn       serial frame line, driven by the upstream encoder or the bench
//   state       last successfully decoded state vector
//   stateValid  one-cycle pulse: state just updated
//   frameErr    one-cycle pulse: malformed frame abandoned
//   busy        high while a frame is being received
// Modports:
//   master  the side that drives the serial line and consumes the results
//   slave   the decoder itself
interface state_frame_decoder_if #(
  parameter int STATE_LENGTH = 7
);
  logic                    serIn;
  logic [STATE_LENGTH-1:0] state;
  logic                    stateValid;
  logic                    frameErr;
  logic                    busy;

  modport master (output serIn, input state, stateValid, frameErr, busy);
  modport slave  (input serIn, output state, stateValid, frameErr, busy);
endinterface

// File: rtl/state_frame_decoder.sv
// Purpose: recovers a STATE_LENGTH-bit state vector from the single-wire serial
//          frame of the state encoder. Frame on the synchronized line:
//          HEADER_ON highs, HEADER_GAP lows, per bit {d,0,0} MSB first,
//          CLOSER_ON highs, then at least one low. A good frame updates state and
//          pulses stateValid; a malformed one pulses frameErr and the decoder
//          waits for IDLE_GAP consecutive lows before re-arming.
// Ports:
//   clk    system clock, one line symbol per cycle
//   rst_n  asynchronous reset, active low
//   bus    state_frame_decoder_if.slave (serIn in; state, stateValid,
//          frameErr, busy out)
module state_frame_decoder #(
  parameter int STATE_LENGTH = 7,
  parameter int HEADER_ON    = 3,
  parameter int HEADER_GAP   = 4,
  parameter int CLOSER_ON    = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_GAP     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  state_frame_decoder_if.slave  bus
);

  localparam int CNT_MAX_A = (HEADER_ON + 1 > HEADER_GAP) ? HEADER_ON + 1 : HEADER_GAP;
  localparam int CNT_MAX_B = (CLOSER_ON + 1 > IDLE_GAP) ? CLOSER_ON + 1 : IDLE_GAP;
  localparam int CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int IDX_W     = (STATE_LENGTH > 1) ? $clog2(STATE_LENGTH) : 1;

  typedef enum logic [2:0] {
    IDLE, HDR_HIGH, HDR_GAP, BITS, CLOSE_HIGH, WAIT_LOW
  } fsm_t;

  logic [SYNC_STAGES-1:0]  r_sync;
  fsm_t                    r_fsm, w_fsm_nxt;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]        r_idx, w_idx_nxt;
  logic [1:0]              r_phase, w_phase_nxt;
  logic [STATE_LENGTH-1:0] r_shift, w_shift_nxt;
  logic [STATE_LENGTH-1:0] r_state;
  logic                    r_valid, r_err;
  logic                    w_s, w_commit, w_err;

  assign w_s = r_sync[SYNC_STAGES-1];

  // Next-state logic. COMMIT and ERROR are transient: they act on the edge of
  // the deciding sample and register a strobe for the following cycle.
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_phase_nxt = r_phase;
    w_shift_nxt = r_shift;
    w_commit    = 1'b0;
    w_err       = 1'b0;
    case (r_fsm)
      IDLE: begin
        if (w_s) begin
          w_fsm_nxt = HDR_HIGH;
          w_cnt_nxt = CNT_W'(1);
        end
      end
      HDR_HIGH: begin
        if (w_s) begin
          if (r_cnt == CNT_W'(HEADER_ON)) w_err = 1'b1;
          else                            w_cnt_nxt = r_cnt + 1'b1;
        end else if (r_cnt == CNT_W'(HEADER_ON)) begin
          // The low that ends the header is the first gap sample.
          if (HEADER_GAP == 1) begin
            w_fsm_nxt   = BITS;
            w_idx_nxt   = IDX_W'(STATE_LENGTH - 1);
            w_phase_nxt = 2'd0;
          end else begin
            w_fsm_nxt = HDR_GAP;
            w_cnt_nxt = CNT_W'(1);
          end
        end else begin
          // Short pulses while idle are line noise, dropped without an error.
          w_fsm_nxt = IDLE;
        end
      end
      HDR_GAP: begin
        if (w_s) begin
          w_err = 1'b1;
        end else if (r_cnt == CNT_W'(HEADER_GAP - 1)) begin
          w_fsm_nxt   = BITS;
          w_idx_nxt   = IDX_W'(STATE_LENGTH - 1);
          w_phase_nxt = 2'd0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      BITS: begin
        case (r_phase)
          2'd0: begin
            w_shift_nxt[r_idx] = w_s;
            w_phase_nxt        = 2'd1;
          end
          2'd1: begin
            if (w_s) w_err = 1'b1;
            else     w_phase_nxt = 2'd2;
          end
          default: begin
            if (w_s) begin
              w_err = 1'b1;
            end else if (r_idx == '0) begin
              w_fsm_nxt = CLOSE_HIGH;
              w_cnt_nxt = '0;
            end else begin
              w_idx_nxt   = r_idx - 1'b1;
              w_phase_nxt = 2'd0;
            end
          end
        endcase
      end
      CLOSE_HIGH: begin
        if (w_s) begin
          if (r_cnt == CNT_W'(CLOSER_ON)) w_err = 1'b1;
          else                            w_cnt_nxt = r_cnt + 1'b1;
        end else if (r_cnt == CNT_W'(CLOSER_ON)) begin
          w_commit  = 1'b1;
          w_fsm_nxt = IDLE;
        end else begin
          w_err = 1'b1;
        end
      end
      WAIT_LOW: begin
        if (w_s) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == CNT_W'(IDLE_GAP - 1)) begin
          w_fsm_nxt = IDLE;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_fsm_nxt = IDLE;
    endcase
    if (w_err) begin
      w_fsm_nxt = WAIT_LOW;
      w_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_fsm   <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_phase <= '0;
      r_state <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_sync[0] <= bus.serIn;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      r_fsm   <= w_fsm_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_phase <= w_phase_nxt;
      r_valid <= w_commit;
      r_err   <= w_err;
      if (w_commit) r_state <= r_shift;
    end
  end

  // Shift register is pure data: every bit is rewritten before a commit.
  always_ff @(posedge clk) begin
    r_shift <= w_shift_nxt;
  end

  assign bus.state      = r_state;
  assign bus.stateValid = r_valid;
  assign bus.frameErr   = r_err;
  assign bus.busy       = (r_fsm == HDR_HIGH) || (r_fsm == HDR_GAP) ||
                          (r_fsm == BITS)     || (r_fsm == CLOSE_HIGH);

endmodule

// File: tb/tb_state_frame_decoder.sv
module tb_state_frame_decoder;
  localparam int SL = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  state_frame_decoder_if #(.STATE_LENGTH(SL)) sfd_if ();

  state_frame_decoder #(
    .STATE_LENGTH(SL), .HEADER_ON(3), .HEADER_GAP(4),
    .CLOSER_ON(2), .SYNC_STAGES(2), .IDLE_GAP(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sfd_if)
  );

  typedef struct packed {
    logic          is_err;
    logic [SL-1:0] st;
  } ev_t;

  ev_t           exp_q[$];
  ev_t           mon_ev;
  int            total = 0;
  int            bad   = 0;
  logic [SL-1:0] exp_state = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Monitor: every strobe pops one expected event from the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (sfd_if.stateValid || sfd_if.frameErr)) begin
      check("strobe_exclusive", {31'd0, sfd_if.stateValid & sfd_if.frameErr}, 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got valid=%0b err=%0b want none",
                 sfd_if.stateValid, sfd_if.frameErr);
      end else begin
        mon_ev = exp_q.pop_front();
        check("strobe_kind_is_err", {31'd0, sfd_if.frameErr}, {31'd0, mon_ev.is_err});
        check("strobe_state", {25'd0, sfd_if.state}, {25'd0, mon_ev.st});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic sym(input logic b);
    @(negedge clk);
    sfd_if.serIn = b;
  endtask

  task automatic lows(input int n);
    repeat (n) sym(1'b0);
  endtask

  // Sends one frame; inj_bit>=0 puts a high in phase1 after that bit and stops.
  task automatic send_frame(input logic [SL-1:0] v, input int hdr, input int clo,
                            input int inj_bit, input logic expect_err);
    if (expect_err) exp_q.push_back({1'b1, exp_state});
    else begin
      exp_q.push_back({1'b0, v});
      exp_state = v;
    end
    repeat (hdr) sym(1'b1);
    lows(4);
    for (int i = SL - 1; i >= 0; i--) begin
      sym(v[i]);
      if (i == inj_bit) begin
        sym(1'b1);
        return;
      end
      lows(2);
    end
    repeat (clo) sym(1'b1);
    sym(1'b0);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s: got %0d pending events want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    logic [SL-1:0] part;
    int busy_cnt;
    sfd_if.serIn = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", {25'd0, sfd_if.state}, 32'd0);
    check("rst_valid", {31'd0, sfd_if.stateValid}, 32'd0);
    check("rst_err", {31'd0, sfd_if.frameErr}, 32'd0);
    check("rst_busy", {31'd0, sfd_if.busy}, 32'd0);
    rst_n = 1'b1;
    lows(3);

    // Clean frame.
    send_frame(7'h53, 3, 2, -1, 1'b0);
    lows(2);
    drain("t1_drain");

    // Back-to-back frames with a single separating low.
    send_frame(7'h7F, 3, 2, -1, 1'b0);
    send_frame(7'h00, 3, 2, -1, 1'b0);
    lows(2);
    drain("t2_drain");

    // Header too long, then a clean frame after the line settles.
    send_frame(7'h2A, 4, 2, -1, 1'b1);
    lows(4);
    send_frame(7'h2A, 3, 2, -1, 1'b0);
    lows(2);
    drain("t3_drain");

    // Spacer violation after bit4, then exactly four lows before the next frame.
    send_frame(7'h3C, 3, 2, 4, 1'b1);
    lows(4);
    send_frame(7'h11, 3, 2, -1, 1'b0);
    lows(2);
    drain("t4_drain");

    // Closer too short, then closer too long.
    send_frame(7'h66, 3, 1, -1, 1'b1);
    lows(4);
    send_frame(7'h19, 3, 3, -1, 1'b1);
    lows(5);
    drain("t5_drain");
    check("t5_state_held", {25'd0, sfd_if.state}, 32'h11);

    // Reset in the middle of a frame at bit 3.
    part = 7'h5A;
    repeat (3) sym(1'b1);
    lows(4);
    for (int i = SL - 1; i >= 3; i--) begin
      sym(part[i]);
      if (i != 3) lows(2);
    end
    lows(1);
    check("t6_busy_before_rst", {31'd0, sfd_if.busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_state", {25'd0, sfd_if.state}, 32'd0);
    check("t6_rst_busy", {31'd0, sfd_if.busy}, 32'd0);
    check("t6_rst_valid", {31'd0, sfd_if.stateValid}, 32'd0);
    exp_state = '0;
    sfd_if.serIn = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lows(3);
    send_frame(7'h05, 3, 2, -1, 1'b0);
    lows(2);
    drain("t6_drain");

    // Short noise pulses while idle: busy for exactly the pulse width, no strobes.
    for (int w = 1; w <= 2; w++) begin
      busy_cnt = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (sfd_if.busy) busy_cnt++;
        sfd_if.serIn = (i < w);
      end
      check(w == 1 ? "t6_pulse1_busy_cycles" : "t6_pulse2_busy_cycles", busy_cnt, w);
      check("t6_pulse_busy_low", {31'd0, sfd_if.busy}, 32'd0);
    end
    lows(4);
    check("t6_final_state", {25'd0, sfd_if.state}, 32'h05);
    drain("final_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
